alu_issue: RTL
==============

ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have parameter NREG, default 16, number of 32-bit scalar registers (index width 4; r0 reads 0).
REQ-002 SHALL have ports: clk  in  1  rising-edge clock; the single clock domain.
REQ-003 SHALL have ports: rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports: in_valid in 1 / in_ready out 1: instruction handshake; in_opcode in 4; in_rs1, in_rs2, in_rd in 4 each; in_use_imm in 1; in_imm in 32.
REQ-005 SHALL have ports: alu_a out 32, alu_b out 32, alu_op out 4 (to the ALU's inst_a, inst_b, opcode); alu_z in 32 (the ALU's z_inst, combinational).
REQ-006 SHALL have ports: wb_valid out 1 / wb_ready in 1: result handshake; wb_rd out 4; wb_data out 32.

Function
REQ-007 SHALL use opcodes ADD=0, SUB=1, SLT=2, SLTU=3, AND=4, OR=5, XOR=6, SLL=7, SRL=8, SRA=9, MUL=10; others pass through unchanged and yield 0 from the ALU.
REQ-008 SHALL implement two registered stages: EX (ex_valid, rd, operands, op) and WB (wb_valid, wb_rd, wb_data); an instruction accepted at edge T is in EX during cycle T+1 and in WB from cycle T+2, assuming no stall.
REQ-009 SHALL drive alu_a/alu_b/alu_op from EX registers; when ex_valid=0 they SHALL be held at their last values (zero after reset).
REQ-010 SHALL form operands at acceptance: non-shift ops: a=src1, b=use_imm?imm:src2; shift ops (7-9): a=use_imm?imm:src2 (shift amount), b=src1.
REQ-011 SHALL resolve each source index with priority: index 0 -> 0; EX match (ex_valid, ex rd) -> alu_z; WB match (wb_valid, wb_rd) -> wb_data; else register file.
REQ-012 SHALL define ex_adv = ex_valid & (!wb_valid | wb_ready); on ex_adv, WB captures ex rd and alu_z and sets wb_valid.
REQ-013 SHALL clear wb_valid on wb_valid & wb_ready when EX does not advance the same edge.
REQ-014 SHALL drive in_ready = !ex_valid | ex_adv (combinational, no dependence on in_valid).
REQ-015 SHALL clear ex_valid when ex_adv occurs without a new acceptance; simultaneous accept and advance SHALL load the new instruction.
REQ-016 SHALL write wb_data to register wb_rd on the edge where wb_valid & wb_ready, except rd=0 (discarded, not stored).
REQ-017 SHALL, while WB is stalled (wb_valid & !wb_ready), hold wb_rd/wb_data, hold EX, and keep alu_* stable.
REQ-018 SHALL sustain one instruction per cycle with wb_ready held high, including back-to-back dependent instructions (no bubbles).
REQ-019 SHALL keep register file writes and the forwarding in REQ-011 consistent: a read in the same cycle as a write to that index returns the new value.
REQ-020 SHALL perform all arithmetic modulo 2^32; no flags or exceptions.

Reset
REQ-021 SHALL on rst=1 at an edge clear ex_valid, wb_valid, all registers to 0, alu_a/alu_b/wb_data to 0, alu_op/wb_rd to 0, regardless of pending handshakes.
REQ-022 SHALL drive in_ready=1 in the first cycle after reset deasserts; an instruction or result in flight at reset is dropped and never written.

Verification
REQ-023 Independent: ADD r1=r0+imm 5, then ADDI r2=r0+imm 7, wb_ready=1 -> wb (1,5) then (2,7) on consecutive cycles, 2 cycles after each accept.
REQ-024 EX forwarding: r1=imm 3; next cycle SUB r2=r1-imm 1; next SLL r3=r2<<imm 4 -> wb results 3, 2, 32; no bubbles, in_ready stays 1.
REQ-025 Backpressure: hold wb_ready=0 for 3 cycles with 3 instructions issued -> wb_data stable, in_ready=0 after EX and WB fill, no loss or duplication; order preserved on release.
REQ-026 r0: ADD r0=imm 9 then ADD r4=r0+imm 1 -> wb (0,9) then (4,1); r0 reads 0.
REQ-027 Shift/sign: r5=imm 0xFFFFFF00, SRA r6=r5>>>imm 4 -> 0xFFFFFFF0; SRL -> 0x0FFFFFF0; SLT r5<r0 -> 1, SLTU -> 0.
REQ-028 Reset mid-flight: assert rst with EX and WB valid and wb_ready=0 -> next cycle wb_valid=0, in_ready=1, r1 reads 0 afterwards.

Source files
------------

// File: rtl/alu_issue_if.sv
// Instruction, ALU and writeback signal bundle for the alu_issue pipeline.
// slave: the issue unit itself; master: the surrounding core / ALU / consumer.
interface alu_issue_if;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_opcode;
   logic [3:0]  in_rs1;
   logic [3:0]  in_rs2;
   logic [3:0]  in_rd;
   logic        in_use_imm;
   logic [31:0] in_imm;

   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [3:0]  alu_op;
   logic [31:0] alu_z;

   logic        wb_valid;
   logic        wb_ready;
   logic [3:0]  wb_rd;
   logic [31:0] wb_data;

   modport slave (
      input  in_valid, in_opcode, in_rs1, in_rs2, in_rd, in_use_imm, in_imm,
      output in_ready,
      output alu_a, alu_b, alu_op,
      input  alu_z,
      output wb_valid, wb_rd, wb_data,
      input  wb_ready
   );

   modport master (
      output in_valid, in_opcode, in_rs1, in_rs2, in_rd, in_use_imm, in_imm,
      input  in_ready,
      input  alu_a, alu_b, alu_op,
      output alu_z,
      input  wb_valid, wb_rd, wb_data,
      output wb_ready
   );
endinterface

// File: rtl/alu_issue.sv
// Two-stage (EX/WB) issue unit feeding an external combinational ALU, with
// operand forwarding from EX and WB and a scalar register file (r0 reads 0).
module alu_issue #(
   parameter int unsigned NREG = 16
) (
   input  logic       clk,
   input  logic       rst,
   alu_issue_if.slave bus
);

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_SLT  = 4'd2,
      OP_SLTU = 4'd3,
      OP_AND  = 4'd4,
      OP_OR   = 4'd5,
      OP_XOR  = 4'd6,
      OP_SLL  = 4'd7,
      OP_SRL  = 4'd8,
      OP_SRA  = 4'd9,
      OP_MUL  = 4'd10
   } op_e;

   logic [31:0] rf_q [NREG];

   logic        ex_valid_q, ex_valid_d;
   logic [3:0]  ex_rd_q,    ex_rd_d;
   logic [31:0] alu_a_q,    alu_a_d;
   logic [31:0] alu_b_q,    alu_b_d;
   logic [3:0]  alu_op_q,   alu_op_d;

   logic        wb_valid_q, wb_valid_d;
   logic [3:0]  wb_rd_q,    wb_rd_d;
   logic [31:0] wb_data_q,  wb_data_d;

   logic        ex_adv;
   logic        in_ready;
   logic        accept;
   logic        wb_fire;
   logic        is_shift;
   logic [31:0] src1;
   logic [31:0] src2;
   logic [31:0] opnd2;

   // Youngest producer wins: EX result (live on alu_z) beats WB beats the file.
   function automatic logic [31:0] resolve(
      input logic [3:0]  idx,
      input logic        exv,
      input logic [3:0]  exrd,
      input logic [31:0] exz,
      input logic        wbv,
      input logic [3:0]  wbrd,
      input logic [31:0] wbd,
      input logic [31:0] rfv
   );
      if (idx == '0)
         return '0;
      else if (exv && (exrd == idx))
         return exz;
      else if (wbv && (wbrd == idx))
         return wbd;
      else
         return rfv;
   endfunction

   always_comb begin
      ex_adv   = ex_valid_q & (~wb_valid_q | bus.wb_ready);
      in_ready = ~ex_valid_q | ex_adv;
      accept   = bus.in_valid & in_ready;
      wb_fire  = wb_valid_q & bus.wb_ready;
      is_shift = (bus.in_opcode == OP_SLL) || (bus.in_opcode == OP_SRL) ||
                 (bus.in_opcode == OP_SRA);

      src1  = resolve(bus.in_rs1, ex_valid_q, ex_rd_q, bus.alu_z,
                      wb_valid_q, wb_rd_q, wb_data_q, rf_q[bus.in_rs1]);
      src2  = resolve(bus.in_rs2, ex_valid_q, ex_rd_q, bus.alu_z,
                      wb_valid_q, wb_rd_q, wb_data_q, rf_q[bus.in_rs2]);
      opnd2 = bus.in_use_imm ? bus.in_imm : src2;
   end

   always_comb begin
      ex_valid_d = ex_valid_q;
      ex_rd_d    = ex_rd_q;
      alu_a_d    = alu_a_q;
      alu_b_d    = alu_b_q;
      alu_op_d   = alu_op_q;
      wb_valid_d = wb_valid_q;
      wb_rd_d    = wb_rd_q;
      wb_data_d  = wb_data_q;

      // Shifts present the shift amount on a and the shifted value on b.
      if (accept) begin
         ex_valid_d = 1'b1;
         ex_rd_d    = bus.in_rd;
         alu_op_d   = bus.in_opcode;
         alu_a_d    = is_shift ? opnd2 : src1;
         alu_b_d    = is_shift ? src1  : opnd2;
      end else if (ex_adv) begin
         ex_valid_d = 1'b0;
      end

      if (ex_adv) begin
         wb_valid_d = 1'b1;
         wb_rd_d    = ex_rd_q;
         wb_data_d  = bus.alu_z;
      end else if (wb_fire) begin
         wb_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid_q <= 1'b0;
         ex_rd_q    <= '0;
         alu_a_q    <= '0;
         alu_b_q    <= '0;
         alu_op_q   <= '0;
         wb_valid_q <= 1'b0;
         wb_rd_q    <= '0;
         wb_data_q  <= '0;
      end else begin
         ex_valid_q <= ex_valid_d;
         ex_rd_q    <= ex_rd_d;
         alu_a_q    <= alu_a_d;
         alu_b_q    <= alu_b_d;
         alu_op_q   <= alu_op_d;
         wb_valid_q <= wb_valid_d;
         wb_rd_q    <= wb_rd_d;
         wb_data_q  <= wb_data_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < NREG; i++)
            rf_q[i] <= '0;
      end else if (wb_fire && (wb_rd_q != '0)) begin
         rf_q[wb_rd_q] <= wb_data_q;
      end
   end

   assign bus.in_ready = in_ready;
   assign bus.alu_a    = alu_a_q;
   assign bus.alu_b    = alu_b_q;
   assign bus.alu_op   = alu_op_q;
   assign bus.wb_valid = wb_valid_q;
   assign bus.wb_rd    = wb_rd_q;
   assign bus.wb_data  = wb_data_q;

endmodule
